pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and optional skid buffering, replacing the fixed-width, always-advancing inter-stage latches (EX/MEM and siblings) of the MIPS pipeline. It carries a configurable number of data lanes plus a control-signal bundle between two stages. Control bits are forced to zero on bubbles so that a stalled or flushed slot never issues memWrite/regWrite. A saturating stall counter supports performance debug.

## Interface
- DATA_W, 32, width of one data lane (pcAdded, aluResult, ...)
- LANES, 4, number of data lanes packed in inData/outData (lane k at bits [k*DATA_W +: DATA_W])
- CTRL_W, 5, width of control bundle (branch, memWrite, memRead, regWrite, memToReg)
- SKID, 1, 0 = single register with combinational inReady; 1 = two-entry skid buffer with registered inReady
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- inValid  in  1  upstream has a beat
- inReady  out  1  stage accepts a beat this cycle
- inData  in  LANES*DATA_W  upstream data lanes
- inCtrl  in  CTRL_W  upstream control bundle
- flush  in  1  synchronous kill of all held beats (branch taken / exception)
- outValid  out  1  stage holds a beat for downstream
- outReady  in  1  downstream accepts
- outData  out  LANES*DATA_W  held data lanes
- outCtrl  out  CTRL_W  held control, zero whenever outValid=0
- stallCount  out  16  cycles with outValid=1 and outReady=0, saturating

## Operation
- Input transfer: inValid && inReady at a rising edge. Output transfer: outValid && outReady at a rising edge.
- Reset (rst_n=0, async): outValid=0, outData=0, outCtrl=0, stallCount=0, skid entry empty with its data=0, inReady=1.
- SKID=0: inReady = outReady || !outValid (combinational). On an input transfer, the main register loads inData/inCtrl and outValid=1. On an output transfer without an input transfer, outValid=0.
- SKID=1: main entry drives the outputs; skid entry is internal. inReady is a flop equal to !skidValid.
  - Input transfer with main empty, or with main being drained this cycle: beat goes to main.
  - Input transfer with main full and not drained: beat goes to skid. inReady falls next cycle.
  - Output transfer with skid full: main loads skid, skid empties, inReady rises next cycle.
  - Order is always preserved; no beat is duplicated or dropped except by flush.
- Flush (sampled at the edge, highest priority): both entries are invalidated and outValid=0 after the edge. Any input beat offered that cycle is discarded, and inReady=1 after the edge. outData holds its last value and is don't-care.
- outCtrl = held ctrl AND {CTRL_W{outValid}}. This is the bubble-safety rule.
- stallCount increments at each edge where outValid && !outReady, saturates at 16'hFFFF, and is cleared only by reset. Flush does not clear it.

## Timing
- Latency: input transfer at edge N gives outValid/outData at edge N (visible in cycle N+1), i.e. one cycle.
- Throughput: one beat per cycle in both modes while outReady=1.
- SKID=0: inReady has a combinational path from outReady.
- SKID=1: no combinational path from outReady to inReady. After outReady falls, at most one further beat is accepted.
- Simultaneous input and output transfer with SKID=1 and skid empty: main is replaced, outValid stays 1, no bubble.
- Reset asserted mid-transfer: all state clears immediately. The first accepted beat after release appears one cycle after its transfer.

## Test plan
- Reset then stream: SKID=1, beats 0x10..0x17 on lane 0 with outReady=1 and ctrl=5'b01010 -> outData lane 0 = 0x10..0x17 on consecutive cycles, one cycle late, outCtrl=5'b01010 each cycle, stallCount=0.
- Backpressure: SKID=1, outReady=0 for 4 cycles mid-stream -> exactly one extra beat accepted, inReady=0 for the remaining cycles, stallCount=4, no loss or reorder after outReady=1.
- Flush with skid full: flush=1 for one cycle -> outValid=0 and outCtrl=0 next cycle, inReady=1, beat offered during flush never appears downstream.
- Bubble safety: inValid=0 with inCtrl=5'b11111 -> outCtrl stays 5'b00000 throughout.
- SKID=0 regression: same stream under alternating outReady -> inReady tracks outReady||!outValid combinationally, data order intact.
- Saturation and async reset: hold outReady=0 for 70000 cycles -> stallCount=16'hFFFF. Pulse rst_n low between clock edges -> outputs go to reset values immediately.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying LANES data lanes plus a control bundle
// between two pipeline stages, with flush, bubble-safe control output and a
// saturating stall counter.
//
// Handshake: a beat moves upstream->stage at a rising edge where
// inValid && inReady, and stage->downstream at a rising edge where
// outValid && outReady. inValid/inData/inCtrl need not be held by upstream
// when inReady is low; outData/outCtrl stay stable while outValid && !outReady.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int CTRL_W = 5,
  parameter int SKID   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [LANES*DATA_W-1:0] inData,
  input  logic [CTRL_W-1:0]       inCtrl,
  input  logic                    flush,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [LANES*DATA_W-1:0] outData,
  output logic [CTRL_W-1:0]       outCtrl,
  output logic [15:0]             stallCount
);

  localparam int DW = LANES * DATA_W;

  // Main entry: always the one presented downstream.
  logic              main_valid;
  logic [DW-1:0]     main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [15:0]       stall_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = inValid && inReady;
  assign out_xfer = main_valid && outReady;

  generate
    if (SKID == 0) begin : g_single
      // Single register: ready whenever the slot is empty or being drained.
      assign inReady = outReady || !main_valid;

      // Main register: flush wins, then load, then drain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          main_ctrl  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (in_xfer) begin
          main_valid <= 1'b1;
          main_data  <= inData;
          main_ctrl  <= inCtrl;
        end else if (out_xfer) begin
          main_valid <= 1'b0;
        end
      end
    end else begin : g_skid
      // Skid entry catches the one beat accepted after downstream stalls,
      // which lets inReady come from a flop instead of from outReady.
      logic              skid_valid;
      logic [DW-1:0]     skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      logic              ready_q;
      logic              main_valid_n;
      logic              skid_valid_n;
      logic              load_main_in;
      logic              load_main_skid;
      logic              load_skid_in;

      assign inReady = ready_q;

      // Next occupancy and data-move selects for both entries.
      // A full skid forces ready_q low, so an input transfer never coincides
      // with the skid being drained into main.
      always_comb begin
        main_valid_n   = main_valid;
        skid_valid_n   = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
          main_valid_n = 1'b0;
          skid_valid_n = 1'b0;
        end else if (out_xfer) begin
          if (skid_valid) begin
            load_main_skid = 1'b1;
            skid_valid_n   = 1'b0;
          end else if (in_xfer) begin
            load_main_in = 1'b1;
          end else begin
            main_valid_n = 1'b0;
          end
        end else if (in_xfer) begin
          if (main_valid) begin
            load_skid_in = 1'b1;
            skid_valid_n = 1'b1;
          end else begin
            load_main_in = 1'b1;
            main_valid_n = 1'b1;
          end
        end
      end

      // Entry registers and the registered ready flag.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
          skid_ctrl  <= '0;
          ready_q    <= 1'b1;
        end else begin
          main_valid <= main_valid_n;
          skid_valid <= skid_valid_n;
          ready_q    <= !skid_valid_n;
          if (load_main_in) begin
            main_data <= inData;
            main_ctrl <= inCtrl;
          end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
          end
          if (load_skid_in) begin
            skid_data <= inData;
            skid_ctrl <= inCtrl;
          end
        end
      end
    end
  endgenerate

  // Stall counter: cycles a beat waits on downstream; saturates, reset-only clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (main_valid && !outReady && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign outValid   = main_valid;
  assign outData    = main_data;
  // Bubbles never carry live control bits downstream.
  assign outCtrl    = main_ctrl & {CTRL_W{main_valid}};
  assign stallCount = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-register instance
// share one stimulus stream; a queue-based model of each stage predicts what
// must come out, in what order, and when each stage must be ready.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int CTRL_W = 5;
  localparam int DW     = LANES * DATA_W;
  localparam int W      = DW + CTRL_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              inValid = 1'b0;
  logic [DW-1:0]     inData = '0;
  logic [CTRL_W-1:0] inCtrl = '0;
  logic              flush = 1'b0;
  logic              outReady = 1'b0;

  logic              in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0]     out_data1, out_data0;
  logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
  logic [15:0]       stall1, stall0;

  int checks = 0;
  int errors = 0;

  // Model state: beats held by each stage, oldest first, plus stall counts.
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];
  int stall_m1 = 0;
  int stall_m0 = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W), .SKID(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(in_ready1),
    .inData(inData), .inCtrl(inCtrl), .flush(flush), .outValid(out_valid1),
    .outReady(outReady), .outData(out_data1), .outCtrl(out_ctrl1), .stallCount(stall1)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W), .SKID(0)) u_single (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(in_ready0),
    .inData(inData), .inCtrl(inCtrl), .flush(flush), .outValid(out_valid0),
    .outReady(outReady), .outData(out_data0), .outCtrl(out_ctrl0), .stallCount(stall0)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  always @(negedge rst_n) begin
    exp_q1.delete();
    exp_q0.delete();
    stall_m1 = 0;
    stall_m0 = 0;
  end

  // At each edge: count stalls, pop and compare delivered beats, then push accepted beats.
  always @(posedge clk) begin
    if (rst_n) begin
      logic r1, r0;
      logic [W-1:0] e;
      r1 = exp_q1.size() < 2;
      r0 = outReady || (exp_q0.size() == 0);
      if (exp_q1.size() > 0 && !outReady && stall_m1 < 65535) stall_m1++;
      if (exp_q0.size() > 0 && !outReady && stall_m0 < 65535) stall_m0++;
      if (exp_q1.size() > 0 && outReady) begin
        e = exp_q1.pop_front();
        chk("skid_out_beat", {out_data1, out_ctrl1}, e);
      end
      if (exp_q0.size() > 0 && outReady) begin
        e = exp_q0.pop_front();
        chk("single_out_beat", {out_data0, out_ctrl0}, e);
      end
      if (flush) begin
        exp_q1.delete();
        exp_q0.delete();
      end else begin
        if (inValid && r1) exp_q1.push_back({inData, inCtrl});
        if (inValid && r0) exp_q0.push_back({inData, inCtrl});
      end
    end
  end

  // Mid-cycle view: occupancy, readiness, bubble safety and stall count.
  always @(negedge clk) begin
    chk("skid_out_valid", out_valid1, exp_q1.size() > 0);
    chk("skid_in_ready", in_ready1, exp_q1.size() < 2);
    chk("skid_stall", stall1, stall_m1);
    chk("single_out_valid", out_valid0, exp_q0.size() > 0);
    chk("single_in_ready", in_ready0, outReady || (exp_q0.size() == 0));
    chk("single_stall", stall0, stall_m0);
    if (exp_q1.size() == 0) chk("skid_bubble_ctrl", out_ctrl1, 0);
    if (exp_q0.size() == 0) chk("single_bubble_ctrl", out_ctrl0, 0);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = $urandom;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic r, input logic f);
    inValid  = v;
    inData   = d;
    inCtrl   = c;
    outReady = r;
    flush    = f;
  endtask

  task automatic lane0_beat(input logic [31:0] val, output logic [DW-1:0] d);
    d = rand_data();
    d[DATA_W-1:0] = val;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    int idx;
    int acc;
    int s_before;

    repeat (3) step();
    chk("reset_in_ready", in_ready1, 1);
    chk("reset_out_data", out_data1, 0);
    chk("reset_stall", stall1, 0);
    rst_n = 1'b1;
    step();

    // Stream 0x10..0x17 with downstream always ready.
    for (int i = 0; i < 8; i++) begin
      lane0_beat(32'h10 + i, d);
      drive(1'b1, d, 5'b01010, 1'b1, 1'b0);
      step();
      chk("stream_lane0", out_data1[DATA_W-1:0], 32'h10 + i);
      chk("stream_ctrl", out_ctrl1, 5'b01010);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) step();
    chk("stream_no_stall", stall1, 0);

    // Backpressure: downstream stalls for 4 cycles mid-stream.
    idx = 0;
    for (int i = 0; i < 2; i++) begin
      lane0_beat(32'h20 + idx, d);
      drive(1'b1, d, 5'b00110, 1'b1, 1'b0);
      step();
      idx++;
    end
    s_before = stall1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      lane0_beat(32'h20 + idx, d);
      drive(1'b1, d, 5'b00110, 1'b0, 1'b0);
      if (in_ready1) begin
        acc++;
        idx++;
      end
      step();
    end
    chk("bp_extra_beats", acc, 1);
    chk("bp_stall_delta", stall1 - s_before, 4);
    for (int i = 0; i < 12 && idx < 12; i++) begin
      lane0_beat(32'h20 + idx, d);
      drive(1'b1, d, 5'b00110, 1'b1, 1'b0);
      if (in_ready1) idx++;
      step();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) step();

    // Flush with skid full; the beat offered during flush must vanish.
    for (int i = 0; i < 3; i++) begin
      lane0_beat(32'h30 + i, d);
      drive(1'b1, d, 5'b11011, 1'b0, 1'b0);
      step();
    end
    lane0_beat(32'hDEAD, d);
    drive(1'b1, d, 5'b11111, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 5'b11111, 1'b0, 1'b0);
    chk("flush_out_valid", out_valid1, 0);
    chk("flush_out_ctrl", out_ctrl1, 0);
    chk("flush_in_ready", in_ready1, 1);
    drive(1'b0, '0, 5'b11111, 1'b1, 1'b0);
    repeat (3) step();

    // Bubble safety: live-looking control with no valid beat.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, rand_data(), 5'b11111, 1'($urandom_range(0, 1)), 1'b0);
      step();
      chk("bubble_ctrl_skid", out_ctrl1, 0);
      chk("bubble_ctrl_single", out_ctrl0, 0);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_data(), CTRL_W'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      step();
    end

    // Asynchronous reset pulse between edges with beats in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_data(), 5'b10101, 1'b0, 1'b0);
      step();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", out_valid1, 0);
    chk("areset_out_data", out_data1, 0);
    chk("areset_out_ctrl", out_ctrl1, 0);
    chk("areset_stall", stall1, 0);
    chk("areset_in_ready", in_ready1, 1);
    chk("areset_single_valid", out_valid0, 0);
    chk("areset_single_data", out_data0, 0);
    #1 rst_n = 1'b1;
    drive(1'b1, rand_data(), 5'b00001, 1'b1, 1'b0);
    step();
    chk("areset_first_beat_latency", out_valid1, 1);
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 1) == 1, rand_data(), CTRL_W'($urandom),
            $urandom_range(0, 2) != 0, 1'b0);
      step();
    end

    // Saturation: hold one beat against a stalled downstream.
    drive(1'b1, rand_data(), 5'b01100, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (70000) step();
    chk("stall_saturate_skid", stall1, 16'hFFFF);
    chk("stall_saturate_single", stall0, 16'hFFFF);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (4) step();
    chk("stall_held_after_drain", stall1, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
